// File: rtl/inst_decode_if.sv
// Fetch-byte and decode-result bundle between fetch, decode and execute.
// "slave" is the decode stage's view; "master" is the fetch/execute side.
interface inst_decode_if #(
  parameter int WORD_W = 16
);
  logic              flush;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       inst;
  logic [WORD_W-1:0] rhs;
  logic              inst_nop;
  logic              inst_out_lo;
  logic              inst_out_hi;
  logic              inst_load;
  logic              inst_add;
  logic              inst_sub;
  logic              inst_and;
  logic              inst_unknown;
  logic              source_imm;
  logic              source_ram;
  logic [7:0]        ram_addr;

  modport slave (
    input  flush, in_valid, in_byte, out_ready,
    output in_ready, out_valid, inst, rhs,
           inst_nop, inst_out_lo, inst_out_hi, inst_load,
           inst_add, inst_sub, inst_and, inst_unknown,
           source_imm, source_ram, ram_addr
  );

  modport master (
    output flush, in_valid, in_byte, out_ready,
    input  in_ready, out_valid, inst, rhs,
           inst_nop, inst_out_lo, inst_out_hi, inst_load,
           inst_add, inst_sub, inst_and, inst_unknown,
           source_imm, source_ram, ram_addr
  );
endinterface

// File: rtl/inst_decode_stage.sv
// Byte-serial instruction decode stage: assembles a 16-bit instruction plus
// optional little-endian operand bytes, then holds the decode for execute.
module inst_decode_stage #(
  parameter int WORD_W     = 16,
  parameter int DATA_BYTES = 1
) (
  input  logic          clk,
  input  logic          rst,
  inst_decode_if.slave  bus
);

  typedef enum logic [1:0] {S_HI, S_LO, S_DATA, S_OUT} state_t;

  localparam logic [2:0] LAST = 3'(DATA_BYTES - 1);

  state_t            state_q, state_d;
  logic [15:0]       inst_q, inst_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [2:0]        count_q, count_d;
  logic              in_fire;
  logic [2:0]        mode;
  logic [WORD_W-1:0] imm_w;

  assign in_fire = bus.in_valid & bus.in_ready;
  assign mode    = inst_q[10:8];
  assign imm_w   = WORD_W'(inst_q[7:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_HI;
      inst_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    data_d  = data_q;
    count_d = count_q;
    if (bus.flush) begin
      state_d = S_HI;
      count_d = '0;
    end else begin
      case (state_q)
        S_HI: if (in_fire) begin
          inst_d[15:8] = bus.in_byte;
          state_d      = S_LO;
        end
        S_LO: if (in_fire) begin
          inst_d[7:0] = bus.in_byte;
          // Data fetch depends only on mode, so unknown opcodes keep the stream aligned.
          if (inst_q[15] && (mode == 3'd2 || mode == 3'd3)) begin
            state_d = S_DATA;
            count_d = '0;
            data_d  = '0;
          end else begin
            state_d = S_OUT;
          end
        end
        S_DATA: if (in_fire) begin
          for (int b = 0; b < DATA_BYTES; b++)
            if (count_q == 3'(b)) data_d[8*b +: 8] = bus.in_byte;
          count_d = count_q + 3'd1;
          if (count_q == LAST) state_d = S_OUT;
        end
        S_OUT: if (bus.out_ready) state_d = S_HI;
        default: state_d = S_HI;
      endcase
    end
  end

  always_comb begin
    bus.in_ready     = (state_q != S_OUT) && !rst;
    bus.out_valid    = (state_q == S_OUT);
    bus.inst         = inst_q;
    bus.rhs          = '0;
    bus.inst_nop     = 1'b0;
    bus.inst_out_lo  = 1'b0;
    bus.inst_out_hi  = 1'b0;
    bus.inst_load    = 1'b0;
    bus.inst_add     = 1'b0;
    bus.inst_sub     = 1'b0;
    bus.inst_and     = 1'b0;
    bus.inst_unknown = 1'b0;
    bus.source_imm   = 1'b0;
    bus.source_ram   = 1'b0;
    bus.ram_addr     = '0;
    if (state_q == S_OUT) begin
      if (!inst_q[15]) begin
        case (inst_q[15:8])
          8'h00:   bus.inst_nop     = 1'b1;
          8'h08:   bus.inst_out_lo  = 1'b1;
          8'h09:   bus.inst_out_hi  = 1'b1;
          default: bus.inst_unknown = 1'b1;
        endcase
      end else if (mode > 3'd4 || inst_q[14:11] > 4'd3) begin
        bus.inst_unknown = 1'b1;
      end else begin
        case (inst_q[14:11])
          4'd0:    bus.inst_load = 1'b1;
          4'd1:    bus.inst_add  = 1'b1;
          4'd2:    bus.inst_sub  = 1'b1;
          default: bus.inst_and  = 1'b1;
        endcase
        case (mode)
          3'd0: begin bus.rhs = imm_w;       bus.source_imm = 1'b1; end
          3'd1: begin bus.rhs = imm_w << 8;  bus.source_imm = 1'b1; end
          3'd2: begin bus.rhs = data_q;      bus.source_imm = 1'b1; end
          3'd3: begin bus.rhs = data_q << 8; bus.source_imm = 1'b1; end
          default: begin
            bus.rhs        = imm_w;
            bus.source_ram = 1'b1;
            bus.ram_addr   = inst_q[7:0];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Scoreboarded bench for inst_decode_stage at 16/1 and 32/4 configurations.
module tb_inst_decode_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_decode_if #(.WORD_W(16)) if16 ();
  inst_decode_if #(.WORD_W(32)) if32 ();

  inst_decode_stage #(.WORD_W(16), .DATA_BYTES(1)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  inst_decode_stage #(.WORD_W(32), .DATA_BYTES(4)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));

  // {inst[15:0], rhs[31:0], nop,out_lo,out_hi,load,add,sub,and,unknown, imm, ram, ram_addr[7:0]}
  logic [65:0] obs16, obs32, exp_v;
  assign obs16 = {if16.inst, 16'h0000, if16.rhs,
                  if16.inst_nop, if16.inst_out_lo, if16.inst_out_hi, if16.inst_load,
                  if16.inst_add, if16.inst_sub, if16.inst_and, if16.inst_unknown,
                  if16.source_imm, if16.source_ram, if16.ram_addr};
  assign obs32 = {if32.inst, if32.rhs,
                  if32.inst_nop, if32.inst_out_lo, if32.inst_out_hi, if32.inst_load,
                  if32.inst_add, if32.inst_sub, if32.inst_and, if32.inst_unknown,
                  if32.source_imm, if32.source_ram, if32.ram_addr};

  localparam logic [7:0] F_NOP = 8'h80, F_OLO = 8'h40, F_OHI = 8'h20, F_LD = 8'h10,
                         F_ADD = 8'h08, F_SUB = 8'h04, F_AND = 8'h02, F_UNK = 8'h01;

  logic [65:0] q16[$];
  logic [65:0] q32[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [65:0] pack(input logic [15:0] i, input logic [31:0] r,
                                       input logic [7:0] f, input logic imm,
                                       input logic ram, input logic [7:0] a);
    return {i, r, f, imm, ram, a};
  endfunction

  task automatic put16(input logic [7:0] b);
    if16.in_valid = 1'b1;
    if16.in_byte  = b;
    @(negedge clk);
    if16.in_valid = 1'b0;
  endtask

  task automatic put32(input logic [7:0] b);
    if32.in_valid = 1'b1;
    if32.in_byte  = b;
    @(negedge clk);
    if32.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b0 || obs16 !== 66'd0) begin
      miscompares++;
      $display("FAIL reset16: out_valid=%b in_ready=%b obs=%h, required 0 0 0", if16.out_valid, if16.in_ready, obs16);
    end
    vectors++;
    if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b0 || obs32 !== 66'd0) begin
      miscompares++;
      $display("FAIL reset32: out_valid=%b in_ready=%b obs=%h, required 0 0 0", if32.out_valid, if32.in_ready, obs32);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b, required 1 0", if16.in_ready, if16.out_valid);
    end
  endtask

  task automatic test_load_imm;
    if16.out_ready = 1'b1;
    q16.push_back(pack(16'h802A, 32'h0000002A, F_LD, 1'b1, 1'b0, 8'h00));
    put16(8'h80);
    put16(8'h2A);
    exp_v = q16.pop_front();
    vectors++;
    if (if16.out_valid !== 1'b1 || obs16 !== exp_v) begin
      miscompares++;
      $display("FAIL load_imm: valid=%b obs=%h, required 1 %h", if16.out_valid, obs16, exp_v);
    end
    @(negedge clk);
    vectors++;
    if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_return: out_valid=%b in_ready=%b, required 0 1", if16.out_valid, if16.in_ready);
    end
  endtask

  task automatic test_add_data;
    if16.out_ready = 1'b0;
    q16.push_back(pack(16'h8B12, 32'h00003400, F_ADD, 1'b1, 1'b0, 8'h00));
    put16(8'h8B);
    put16(8'h12);
    vectors++;
    if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL add_wait_data: out_valid=%b in_ready=%b, required 0 1", if16.out_valid, if16.in_ready);
    end
    put16(8'h34);
    exp_v = q16.pop_front();
    vectors++;
    if (if16.out_valid !== 1'b1 || if16.in_ready !== 1'b0 || obs16 !== exp_v) begin
      miscompares++;
      $display("FAIL add_data: valid=%b ready=%b obs=%h, required 1 0 %h", if16.out_valid, if16.in_ready, obs16, exp_v);
    end
    if16.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_stall_ram;
    if16.out_ready = 1'b0;
    q16.push_back(pack(16'h9407, 32'h00000007, F_SUB, 1'b0, 1'b1, 8'h07));
    put16(8'h94);
    put16(8'h07);
    exp_v = q16.pop_front();
    for (int c = 0; c < 5; c++) begin
      if16.in_valid = 1'b1;
      if16.in_byte  = 8'hEE;
      vectors++;
      if (if16.out_valid !== 1'b1 || if16.in_ready !== 1'b0 || obs16 !== exp_v) begin
        miscompares++;
        $display("FAIL stall_ram[%0d]: valid=%b ready=%b obs=%h, required 1 0 %h", c, if16.out_valid, if16.in_ready, obs16, exp_v);
      end
      @(negedge clk);
    end
    if16.in_valid  = 1'b0;
    if16.out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b, required 0 1", if16.out_valid, if16.in_ready);
    end
  endtask

  task automatic test_back_to_back;
    if16.out_ready = 1'b1;
    q16.push_back(pack(16'h85FF, 32'h0, F_UNK, 1'b0, 1'b0, 8'h00));
    q16.push_back(pack(16'h0900, 32'h0, F_OHI, 1'b0, 1'b0, 8'h00));
    put16(8'h85);
    put16(8'hFF);
    exp_v = q16.pop_front();
    vectors++;
    if (if16.out_valid !== 1'b1 || obs16 !== exp_v) begin
      miscompares++;
      $display("FAIL reserved_mode: valid=%b obs=%h, required 1 %h", if16.out_valid, obs16, exp_v);
    end
    @(negedge clk);
    put16(8'h09);
    put16(8'h00);
    exp_v = q16.pop_front();
    vectors++;
    if (if16.out_valid !== 1'b1 || obs16 !== exp_v) begin
      miscompares++;
      $display("FAIL out_hi: valid=%b obs=%h, required 1 %h", if16.out_valid, obs16, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_flush;
    if16.out_ready = 1'b1;
    put16(8'h8A);
    if16.flush    = 1'b1;
    if16.in_valid = 1'b1;
    if16.in_byte  = 8'h55;
    @(negedge clk);
    if16.flush    = 1'b0;
    if16.in_valid = 1'b0;
    q16.push_back(pack(16'h0800, 32'h0, F_OLO, 1'b0, 1'b0, 8'h00));
    put16(8'h08);
    put16(8'h00);
    exp_v = q16.pop_front();
    vectors++;
    if (if16.out_valid !== 1'b1 || obs16 !== exp_v) begin
      miscompares++;
      $display("FAIL flush_partial: valid=%b obs=%h, required 1 %h", if16.out_valid, obs16, exp_v);
    end
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (if16.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_extra: out_valid=%b, required 0", if16.out_valid);
    end
    // Discard a pending result while out_ready is high.
    if16.out_ready = 1'b0;
    put16(8'h80);
    put16(8'h01);
    if16.flush     = 1'b1;
    if16.out_ready = 1'b1;
    @(negedge clk);
    if16.flush = 1'b0;
    vectors++;
    if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_out: out_valid=%b in_ready=%b, required 0 1", if16.out_valid, if16.in_ready);
    end
  endtask

  task automatic test_reset_mid_data;
    if16.out_ready = 1'b1;
    put16(8'h8A);
    put16(8'h11);
    vectors++;
    if (if16.in_ready !== 1'b1 || if16.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pre_reset_data: in_ready=%b out_valid=%b, required 1 0", if16.in_ready, if16.out_valid);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (if16.in_ready !== 1'b0 || if16.out_valid !== 1'b0 || obs16 !== 66'd0) begin
      miscompares++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b obs=%h, required 0 0 0", if16.in_ready, if16.out_valid, obs16);
    end
    @(negedge clk);
    rst = 1'b0;
    q16.push_back(pack(16'h9C3C, 32'h0000003C, F_AND, 1'b0, 1'b1, 8'h3C));
    put16(8'h9C);
    put16(8'h3C);
    exp_v = q16.pop_front();
    vectors++;
    if (if16.out_valid !== 1'b1 || obs16 !== exp_v) begin
      miscompares++;
      $display("FAIL after_reset: valid=%b obs=%h, required 1 %h", if16.out_valid, obs16, exp_v);
    end
    @(negedge clk);
  endtask

  task automatic test_wide;
    logic [7:0] hdr [3];
    logic [31:0] res [3];
    hdr[0] = 8'h82; res[0] = 32'h12345678;
    hdr[1] = 8'h83; res[1] = 32'h34567800;
    hdr[2] = 8'h81; res[2] = 32'h0000AB00;
    if32.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        q32.push_back(pack({hdr[k], 8'h00}, res[k], F_LD, 1'b1, 1'b0, 8'h00));
        put32(hdr[k]);
        put32(8'h00);
        put32(8'h78);
        put32(8'h56);
        put32(8'h34);
        put32(8'h12);
      end else begin
        q32.push_back(pack({hdr[k], 8'hAB}, res[k], F_LD, 1'b1, 1'b0, 8'h00));
        put32(hdr[k]);
        put32(8'hAB);
      end
      exp_v = q32.pop_front();
      vectors++;
      if (if32.out_valid !== 1'b1 || obs32 !== exp_v) begin
        miscompares++;
        $display("FAIL wide[%0d]: valid=%b obs=%h, required 1 %h", k, if32.out_valid, obs32, exp_v);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    if16.flush = 1'b0; if16.in_valid = 1'b0; if16.in_byte = 8'h00; if16.out_ready = 1'b0;
    if32.flush = 1'b0; if32.in_valid = 1'b0; if32.in_byte = 8'h00; if32.out_ready = 1'b0;
    test_reset;
    test_load_imm;
    test_add_data;
    test_stall_ram;
    test_back_to_back;
    test_flush;
    test_reset_mid_data;
    test_wide;
    vectors++;
    if (q16.size() != 0 || q32.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: pending=%0d/%0d, required 0/0", q16.size(), q32.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
